// File: rtl/seq_mul32.sv
// Sequential 32x32 unsigned shift-add multiplier driving a carry-select adder.
// Optional macro SEQ_MUL_ZERO_SKIP_EN: zero operands bypass RUN (latency 1).

module csadd32_blk #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);
  logic [W:0] sum0, sum1;

  // Both carry-in outcomes are precomputed; the incoming carry only selects.
  always_comb begin
    sum0 = {1'b0, a} + {1'b0, b};
    sum1 = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, 1'b1};
    {cout, s} = cin ? sum1 : sum0;
  end
endmodule

module csadd32 #(
  parameter int BLK_W = 4
) (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] s,
  output logic        cout
);
  localparam int NBLK = 32 / BLK_W;

  logic [NBLK:0] c;

  assign c[0] = cin;
  assign cout = c[NBLK];

  for (genvar g = 0; g < NBLK; g++) begin : g_blk
    csadd32_blk #(.W(BLK_W)) u_blk (
      .a    (a[g*BLK_W +: BLK_W]),
      .b    (b[g*BLK_W +: BLK_W]),
      .cin  (c[g]),
      .s    (s[g*BLK_W +: BLK_W]),
      .cout (c[g+1])
    );
  end
endmodule

module seq_mul32 #(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] multiplicand,
  input  logic [31:0] multiplier,
  output logic        busy,
  output logic        done,
  output logic [63:0] product
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] mcand_q, mcand_d;
  logic [63:0] product_q, product_d;

  logic [31:0] add_b, add_s;
  logic        add_cout;
  logic        accept;

  assign add_b = lo_q[0] ? mcand_q : 32'd0;

  csadd32 u_add (
    .a    (hi_q),
    .b    (add_b),
    .cin  (1'b0),
    .s    (add_s),
    .cout (add_cout)
  );

  assign accept = start && (state_q != RUN);

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    mcand_d   = mcand_q;
    product_d = product_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          mcand_d = multiplicand;
          hi_d    = 32'd0;
          lo_d    = multiplier;
          count_d = 5'd0;
          state_d = RUN;
`ifdef SEQ_MUL_ZERO_SKIP_EN
          if (multiplicand == 32'd0 || multiplier == 32'd0) begin
            state_d   = DONE;
            product_d = 64'd0;
          end
`endif
        end
      end
      RUN: begin
        // The adder carry becomes the new top bit, so no product bit is lost.
        hi_d    = {add_cout, add_s[31:1]};
        lo_d    = {add_s[0], lo_q[31:1]};
        count_d = count_q + 5'd1;
        if (count_q == 5'(ITER - 1)) begin
          state_d   = DONE;
          product_d = {hi_d, lo_d};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= 5'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      mcand_q   <= 32'd0;
      product_q <= 64'd0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      mcand_q   <= mcand_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign product = product_q;
endmodule

// File: tb/tb_seq_mul32.sv
// Self-checking bench for seq_mul32; expected products come from 64-bit arithmetic.

module tb_seq_mul32;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] multiplicand = '0;
  logic [31:0] multiplier = '0;
  logic        busy;
  logic        done;
  logic [63:0] product;

  int n_tests = 0;
  int n_fail  = 0;

  seq_mul32 dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    r = {32'd0, a} * {32'd0, b};
    return r;
  endfunction

  function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef SEQ_MUL_ZERO_SKIP_EN
    if (a == 32'd0 || b == 32'd0) return 1;
`endif
    return 33;
  endfunction

  // Launches one operation and samples on falling edges until done.
  // lat counts samples after the start edge (1 = first cycle after it).
  // When glitch_at > 0, start is pulsed with A=B=7 at that sample.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int glitch_at,
                        output int lat, output int busy_cnt, output logic [63:0] prod,
                        output bit timeout);
    @(negedge clk);
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    lat      = 1;
    busy_cnt = 0;
    timeout  = 1'b0;
    prod     = '0;
    forever begin
      if (busy) busy_cnt++;
      if (done) begin
        prod = product;
        break;
      end
      if (lat > 100) begin
        timeout = 1'b1;
        break;
      end
      if (glitch_at > 0 && lat == glitch_at) begin
        start = 1'b1; multiplicand = 32'd7; multiplier = 32'd7;
      end else begin
        start = 1'b0; multiplicand = $urandom; multiplier = $urandom;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
  endtask

  task automatic check_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input int glitch_at);
    int lat, bc;
    logic [63:0] p;
    bit to;
    int el;
    el = exp_lat(a, b);
    run_op(a, b, glitch_at, lat, bc, p, to);
    n_tests++;
    if (to) begin
      n_fail++;
      $display("FAIL %s timeout: no done within bound", name);
      return;
    end
    n_tests++;
    if (p !== ref_mul(a, b)) begin
      n_fail++;
      $display("FAIL %s product: got %h want %h", name, p, ref_mul(a, b));
    end
    n_tests++;
    if (lat !== el) begin
      n_fail++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, el);
    end
    n_tests++;
    if (bc !== el - 1) begin
      n_fail++;
      $display("FAIL %s busy cycles: got %0d want %0d", name, bc, el - 1);
    end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s after done: done=%b busy=%b want 0 0", name, done, busy);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 64'd0) begin
      n_fail++;
      $display("FAIL reset: busy=%b done=%b product=%h want 0 0 0", busy, done, product);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    check_op("basic_3x5", 32'd3, 32'd5, 0);
    repeat (5) @(negedge clk);
    n_tests++;
    if (product !== 64'h0F || done !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_hold: product=%h done=%b want 000000000000000f 0", product, done);
    end
  endtask

  task automatic test_all_ones();
    check_op("all_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    check_op("ones_x_1", 32'hFFFF_FFFF, 32'h0000_0001, 0);
  endtask

  task automatic test_ignore_start();
    check_op("ignore_start", 32'h1234_5678, 32'h9ABC_DEF0, 6);
  endtask

  task automatic test_mid_reset();
    bit seen;
    @(negedge clk);
    multiplicand = 32'd10; multiplier = 32'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_busy_before: busy=%b want 1", busy);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 64'd0) begin
      n_fail++;
      $display("FAIL midreset_clear: busy=%b done=%b product=%h want 0 0 0", busy, done, product);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    n_tests++;
    if (seen) begin
      n_fail++;
      $display("FAIL midreset_no_done: saw activity after reset, want none");
    end
    check_op("after_reset_2x4", 32'd2, 32'd4, 0);
  endtask

  task automatic test_back_to_back();
    int n;
    bit hit;
    logic [63:0] mid_p;
    @(negedge clk);
    multiplicand = 32'd6; multiplier = 32'd7; start = 1'b1;
    n = 0;
    hit = 1'b0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (done) begin hit = 1'b1; break; end
    end
    n_tests++;
    if (!hit || n != 33 || product !== 64'd42) begin
      n_fail++;
      $display("FAIL b2b_first: done=%b lat=%0d product=%h want 1 33 000000000000002a", hit, n, product);
    end
    multiplicand = 32'h8000_0000; multiplier = 32'd2;
    n = 0;
    hit = 1'b0;
    mid_p = '0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (n == 10) mid_p = product;
      if (done) begin hit = 1'b1; break; end
    end
    start = 1'b0;
    n_tests++;
    if (mid_p !== 64'd42) begin
      n_fail++;
      $display("FAIL b2b_hold: product=%h during run want 000000000000002a", mid_p);
    end
    n_tests++;
    if (!hit || n != 33 || product !== 64'h1_0000_0000) begin
      n_fail++;
      $display("FAIL b2b_second: done=%b lat=%0d product=%h want 1 33 0000000100000000", hit, n, product);
    end
    @(negedge clk);
  endtask

  task automatic test_zero();
    check_op("zero_a", 32'd0, 32'hDEAD_BEEF, 0);
    check_op("zero_b", 32'hDEAD_BEEF, 32'd0, 0);
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    for (int i = 0; i < 12; i++) begin
      a = $urandom;
      b = $urandom;
      if (i == 3) a = 32'd0;
      if (i == 7) b = 32'hFFFF_FFFF;
      check_op($sformatf("random_%0d", i), a, b, 0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_all_ones();
    test_ignore_start();
    test_mid_reset();
    test_back_to_back();
    test_zero();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
